// File: rtl/fifo_ext.sv
// Synchronous FIFO with level, almost-full/empty flags and sticky overflow/underflow errors.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is a registered read.
module fifo_ext #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                        CLKip,
  input  logic                        RSTi,
  input  logic                        WEi,
  input  logic [DATA_WIDTH-1:0]       DATAi,
  input  logic                        RDi,
  input  logic                        FLUSHi,
  input  logic                        CLRERRi,
  output logic [DATA_WIDTH-1:0]       DATAo,
  output logic                        FULLo,
  output logic                        EMPTYo,
  output logic                        AFULLo,
  output logic                        AEMPTYo,
  output logic [$clog2(FIFO_DEPTH):0] LEVELo,
  output logic                        OVFo,
  output logic                        UNFo
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  we_ok_s;
  logic                  rd_ok_s;
  logic                  ovf_set_s;
  logic                  unf_set_s;
  logic [PW-1:0]         wr_ptr_nxt_s;
  logic [PW-1:0]         rd_ptr_nxt_s;

  // Status decode, access qualification and pointer wrap.
  always_comb begin
    full_s       = (level_r == FULL_LVL);
    empty_s      = (level_r == {LW{1'b0}});
    we_ok_s      = WEi && !full_s && !FLUSHi;
    rd_ok_s      = RDi && !empty_s && !FLUSHi;
    ovf_set_s    = WEi && full_s && !FLUSHi;
    // A read on empty paired with a write is served by nothing but loses nothing either.
    unf_set_s    = RDi && empty_s && !WEi && !FLUSHi;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_ptr_r == LAST_PTR) begin
      wr_ptr_nxt_s = {PW{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PW'(1);
    end
    if (rd_ptr_r == LAST_PTR) begin
      rd_ptr_nxt_s = {PW{1'b0}};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end
  end

  assign FULLo   = full_s;
  assign EMPTYo  = empty_s;
  assign LEVELo  = level_r;
  assign AFULLo  = (int'(level_r) >= AFULL_THRESH);
  assign AEMPTYo = (int'(level_r) <= AEMPTY_THRESH);
  assign OVFo    = ovf_r;
  assign UNFo    = unf_r;

  // Storage array; no write lands while reset is held.
  always_ff @(posedge CLKip) begin
    if (we_ok_s && !RSTi) begin
      mem_r[wr_ptr_r] <= DATAi;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (FLUSHi) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (we_ok_s) begin
        wr_ptr_r <= wr_ptr_nxt_s;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      if (we_ok_s && !rd_ok_s) begin
        level_r <= level_r + LW'(1);
      end else if (rd_ok_s && !we_ok_s) begin
        level_r <= level_r - LW'(1);
      end
    end
  end

  // Sticky error flags; a new event outranks a clear, and flush freezes both.
  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (!FLUSHi) begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (CLRERRi) begin
        ovf_r <= 1'b0;
      end
      if (unf_set_s) begin
        unf_r <= 1'b1;
      end else if (CLRERRi) begin
        unf_r <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign DATAo = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
`else
  logic [DATA_WIDTH-1:0] data_r;

  // Registered read port, loaded only by an accepted read.
  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_ok_s) begin
      data_r <= mem_r[rd_ptr_r];
    end
  end

  assign DATAo = data_r;
`endif

endmodule
